// File: rtl/lc3b_types.sv
// Shared types for the pmem responder: line type and responder FSM states.
package lc3b_types;

  localparam int PMEM_LINE_BITS   = 128;
  localparam int PMEM_OFFSET_BITS = 4;
  localparam int PMEM_COUNT_BITS  = 8;

  typedef logic [PMEM_LINE_BITS-1:0] lc3b_pmem_line;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } pmem_state_t;

endpackage

// File: rtl/pmem_array.sv
// Line-addressed backing store: synchronous write, registered read (read-before-write).
module pmem_array #(
  parameter int IDX_BITS  = 6,
  parameter int LINE_BITS = 128
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [IDX_BITS-1:0]  idx,
  input  logic [LINE_BITS-1:0] wdata,
  output logic [LINE_BITS-1:0] rdata
);

  localparam int DEPTH = 1 << IDX_BITS;

  logic [LINE_BITS-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/pmem_responder.sv
// Memory end of the pmem_read/pmem_write/pmem_resp line protocol with fixed latency.
// Optional protocol checker (proto_err output) enabled by defining PMEM_PROTOCOL_CHECK_EN.
module pmem_responder
  import lc3b_types::*;
#(
  parameter int ADDR_BITS = 16,
  parameter int LINE_BITS = 128,
  parameter int IDX_BITS  = 6,
  parameter int LATENCY   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pmem_read,
  input  logic                 pmem_write,
  input  logic [ADDR_BITS-1:0] pmem_address,
  input  logic [LINE_BITS-1:0] pmem_wdata,
  output logic [LINE_BITS-1:0] pmem_rdata,
  output logic                 pmem_resp
`ifdef PMEM_PROTOCOL_CHECK_EN
  ,
  output logic                 proto_err
`endif
);

  localparam logic [PMEM_COUNT_BITS-1:0] COUNT_INIT = PMEM_COUNT_BITS'(LATENCY - 1);
  localparam int IDX_LO = PMEM_OFFSET_BITS;
  localparam int IDX_HI = PMEM_OFFSET_BITS + IDX_BITS - 1;

  pmem_state_t                state, state_next;
  logic [PMEM_COUNT_BITS-1:0] count_q;
  logic                       op_write_q;
  logic [IDX_BITS-1:0]        idx_q;
  logic [LINE_BITS-1:0]       wdata_q;

  logic                       req;
  logic                       accept;
  logic                       fire;
  logic [IDX_BITS-1:0]        req_idx;
  logic                       arr_we;
  logic [IDX_BITS-1:0]        arr_idx;
  logic [LINE_BITS-1:0]       arr_wdata;
  logic [LINE_BITS-1:0]       arr_rdata;

  // Offset bits and bits above the index select nothing: lines alias modulo the store depth.
  logic unused_addr;
  assign unused_addr = ^{pmem_address[IDX_LO-1:0], pmem_address[ADDR_BITS-1:IDX_HI+1]};

  assign req     = pmem_read | pmem_write;
  assign req_idx = pmem_address[IDX_HI:IDX_LO];
  assign accept  = (state == IDLE) && req;
  // The store is touched on the edge that enters RESP: end of BUSY, or the accept edge itself at LATENCY=1.
  assign fire    = ((state == BUSY) && (count_q == PMEM_COUNT_BITS'(1)))
                 || (accept && (LATENCY == 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count_q    <= '0;
      op_write_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        count_q    <= COUNT_INIT;
        op_write_q <= pmem_write;
        idx_q      <= req_idx;
        wdata_q    <= pmem_wdata;
      end else if (state == BUSY) begin
        count_q <= count_q - PMEM_COUNT_BITS'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    arr_idx    = idx_q;
    arr_wdata  = wdata_q;
    arr_we     = 1'b0;
    case (state)
      IDLE: begin
        arr_idx   = req_idx;
        arr_wdata = pmem_wdata;
        arr_we    = fire && pmem_write;
        if (req) begin
          state_next = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        arr_we = fire && op_write_q;
        if (fire) begin
          state_next = RESP;
        end
      end
      RESP: begin
        pmem_resp  = 1'b1;
        pmem_rdata = op_write_q ? '0 : arr_rdata;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  pmem_array #(
    .IDX_BITS  (IDX_BITS),
    .LINE_BITS (LINE_BITS)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .idx   (arr_idx),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

`ifdef PMEM_PROTOCOL_CHECK_EN
  logic [ADDR_BITS-1:0] addr_q;
  logic                 both_at_accept;
  logic                 line_dropped;
  logic                 addr_moved;

  assign both_at_accept = accept && pmem_read && pmem_write;
  assign line_dropped   = (state != IDLE) && (op_write_q ? !pmem_write : !pmem_read);
  assign addr_moved     = (state == BUSY) && (pmem_address != addr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      proto_err <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= pmem_address;
      end
      if (both_at_accept || line_dropped || addr_moved) begin
        proto_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Bench for pmem_responder: LATENCY=4 instance checked every cycle against a line-store model,
// plus a LATENCY=1 instance with directed checks. Define PMEM_PROTOCOL_CHECK_EN to cover proto_err.
module tb_pmem_responder;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         pmem_read = 1'b0, pmem_write = 1'b0;
  logic [15:0]  pmem_address = '0;
  logic [127:0] pmem_wdata = '0;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  logic         r1_read = 1'b0, r1_write = 1'b0;
  logic [15:0]  r1_address = '0;
  logic [127:0] r1_wdata = '0;
  logic [127:0] r1_rdata;
  logic         r1_resp;
`ifdef PMEM_PROTOCOL_CHECK_EN
  logic         proto_err;
  logic         r1_proto_err;
`endif

  pmem_responder #(.ADDR_BITS(16), .LINE_BITS(128), .IDX_BITS(6), .LATENCY(LAT)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
`ifdef PMEM_PROTOCOL_CHECK_EN
    ,
    .proto_err    (proto_err)
`endif
  );

  pmem_responder #(.ADDR_BITS(16), .LINE_BITS(128), .IDX_BITS(6), .LATENCY(1)) u_dut1 (
    .clk          (clk),
    .rst          (rst),
    .pmem_read    (r1_read),
    .pmem_write   (r1_write),
    .pmem_address (r1_address),
    .pmem_wdata   (r1_wdata),
    .pmem_rdata   (r1_rdata),
    .pmem_resp    (r1_resp)
`ifdef PMEM_PROTOCOL_CHECK_EN
    ,
    .proto_err    (r1_proto_err)
`endif
  );

  int checks   = 0;
  int failures = 0;
  logic [127:0] exp_q [$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Model: edge numbers since reset; a transaction accepted at edge acc completes its
  // store access at edge acc+LAT-1, shows resp for one cycle, and occupies edges up to acc+LAT.
  int           edge_n = 0;
  bit           live = 0;
  int           acc = 0;
  bit           m_op_w = 0;
  int           m_idx = 0;
  logic [127:0] m_wd = '0;
  logic [15:0]  m_addr = '0;
  logic [127:0] mem_m [0:63];
  logic         exp_resp = 1'b0;
  logic [127:0] exp_rdata = '0;
  logic         exp_perr = 1'b0;

  task automatic model_complete();
    exp_resp = 1'b1;
    if (m_op_w) mem_m[m_idx] = m_wd;
    else        exp_rdata = mem_m[m_idx];
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_n = 0; live = 0; exp_resp = 1'b0; exp_rdata = '0; exp_perr = 1'b0;
    end else begin
      edge_n++;
      exp_resp  = 1'b0;
      exp_rdata = '0;
      if (live) begin
        if (m_op_w ? !pmem_write : !pmem_read) exp_perr = 1'b1;
        if (edge_n < acc + LAT && pmem_address != m_addr) exp_perr = 1'b1;
        if (edge_n == acc + LAT - 1) model_complete();
        if (edge_n == acc + LAT) live = 0;
      end else if (pmem_read || pmem_write) begin
        live   = 1;
        acc    = edge_n;
        m_op_w = pmem_write;
        m_idx  = int'(pmem_address[9:4]);
        m_wd   = pmem_wdata;
        m_addr = pmem_address;
        if (pmem_read && pmem_write) exp_perr = 1'b1;
        if (LAT == 1) model_complete();
      end
    end
  end

  bit run = 0;
  initial begin
    wait (run);
    forever begin
      @(negedge clk);
      chk("cyc_resp", pmem_resp, exp_resp);
      chk("cyc_rdata", pmem_rdata, exp_rdata);
`ifdef PMEM_PROTOCOL_CHECK_EN
      chk("cyc_proto_err", proto_err, exp_perr);
`endif
    end
  end

  // Drive one request on instance sel (0: LATENCY=4, 1: LATENCY=1), hold it through the
  // resp cycle and its closing edge, then release. lat = negedges from drive to resp.
  task automatic req(input bit sel, input logic rd, input logic wr, input logic [15:0] a,
                     input logic [127:0] d, output logic [127:0] q, output int lat);
    logic got;
    got = 1'b0; q = '0; lat = 0;
    if (!sel) begin pmem_read = rd; pmem_write = wr; pmem_address = a; pmem_wdata = d; end
    else      begin r1_read = rd; r1_write = wr; r1_address = a; r1_wdata = d; end
    while (!got && lat < 300) begin
      @(negedge clk);
      lat++;
      if (!sel && pmem_resp) begin got = 1'b1; q = pmem_rdata; end
      if (sel && r1_resp)    begin got = 1'b1; q = r1_rdata; end
    end
    chk("resp_seen", got, 1'b1);
    @(negedge clk);
    if (!sel) begin pmem_read = 1'b0; pmem_write = 1'b0; end
    else      begin r1_read = 1'b0; r1_write = 1'b0; end
  endtask

  task automatic wr_line(input bit sel, input logic [15:0] a, input logic [127:0] d);
    logic [127:0] q;
    int lat;
    req(sel, 1'b0, 1'b1, a, d, q, lat);
    chk("wr_latency", lat, sel ? 1 : LAT);
    chk("wr_rdata_zero", q, '0);
  endtask

  task automatic rd_line(input bit sel, input logic [15:0] a, input logic [127:0] exp);
    logic [127:0] q;
    int lat;
    exp_q.push_back(exp);
    req(sel, 1'b1, 1'b0, a, '0, q, lat);
    chk("rd_latency", lat, sel ? 1 : LAT);
    chk("rd_data", q, exp_q.pop_front());
  endtask

  localparam logic [127:0] D_A5 = {16{8'hA5}};
  localparam logic [127:0] D1   = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam logic [127:0] D2   = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] D3   = 128'h1357_9bdf_2468_ace0_0f0f_f0f0_55aa_aa55;
  localparam logic [127:0] D4   = 128'hc0c0_c0c0_0000_0000_ffff_ffff_1234_5678;
  localparam logic [127:0] D5   = 128'h5a5a_5a5a_a5a5_a5a5_0101_0101_8080_8080;
  localparam logic [127:0] D6   = 128'h6666_7777_8888_9999_aaaa_bbbb_cccc_dddd;

  initial begin
    logic [127:0] q;
    int lat;
    logic seen;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_resp", pmem_resp, 1'b0);
    chk("reset_rdata", pmem_rdata, '0);
`ifdef PMEM_PROTOCOL_CHECK_EN
    chk("reset_proto_err", proto_err, 1'b0);
`endif
    run = 1;

    // Write then read back the same line.
    wr_line(0, 16'h0040, D_A5);
    rd_line(0, 16'h0040, D_A5);

    // Read held continuously: back-to-back reads still see full latency each.
    rd_line(0, 16'h0040, D_A5);
    rd_line(0, 16'h0040, D_A5);
    rd_line(0, 16'h0040, D_A5);

    // Aliasing: 0x0410 maps to the same line as 0x0010; offset bits ignored.
    wr_line(0, 16'h0010, D3);
    rd_line(0, 16'h0410, D3);
    rd_line(0, 16'h001f, D3);

    // Both request lines high: behaves as a write, no read data.
    req(0, 1'b1, 1'b1, 16'h00c0, D4, q, lat);
    chk("both_latency", lat, LAT);
    chk("both_rdata_zero", q, '0);
    rd_line(0, 16'h00c0, D4);
`ifdef PMEM_PROTOCOL_CHECK_EN
    chk("proto_err_sticky", proto_err, 1'b1);
`endif

    // Reset two cycles into a write: no response and the old line survives.
    wr_line(0, 16'h0080, D1);
    pmem_write = 1'b1; pmem_address = 16'h0080; pmem_wdata = D2;
    seen = 1'b0;
    repeat (2) begin @(negedge clk); seen |= pmem_resp; end
    #1 rst = 1'b1;
    @(negedge clk);
    seen |= pmem_resp;
    rst = 1'b0;
    pmem_write = 1'b0;
    repeat (LAT + 2) begin @(negedge clk); seen |= pmem_resp; end
    chk("abort_no_resp", seen, 1'b0);
`ifdef PMEM_PROTOCOL_CHECK_EN
    chk("proto_err_cleared", proto_err, 1'b0);
`endif
    rd_line(0, 16'h0080, D1);

`ifdef PMEM_PROTOCOL_CHECK_EN
    // Address moves while busy: flagged, but the latched address is written.
    pmem_write = 1'b1; pmem_address = 16'h0100; pmem_wdata = D6;
    @(negedge clk);
    @(negedge clk);
    pmem_address = 16'h0140;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = pmem_resp; end
    chk("addr_move_resp_seen", seen, 1'b1);
    @(negedge clk);
    pmem_write = 1'b0;
    chk("addr_move_proto_err", proto_err, 1'b1);
    rd_line(0, 16'h0100, D6);
`endif

    // LATENCY=1 instance: resp in the cycle right after the accept edge.
    wr_line(1, 16'h0020, D5);
    rd_line(1, 16'h0020, D5);
    chk("lat1_idle_resp", r1_resp, 1'b0);
    chk("lat1_idle_rdata", r1_rdata, '0);
`ifdef PMEM_PROTOCOL_CHECK_EN
    chk("lat1_proto_err", r1_proto_err, 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
